// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised MEM-stage data memory.
// Holds the RV32 load/store funct3 encodings and the access FSM states.
package mem_pkg;

   localparam int XLEN      = 32;
   localparam int BYTE_W    = 8;
   localparam int CNT_W     = 4;
   localparam int NUM_LANES = XLEN / BYTE_W;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword out of an aligned 32-bit word and
// applies sign or zero extension according to the load funct3.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data
);

   logic [BYTE_W-1:0]   byte_sel;
   logic [2*BYTE_W-1:0] half_sel;

   assign byte_sel = word[{addr_lo, 3'b000} +: BYTE_W];
   assign half_sel = addr_lo[1] ? word[XLEN-1:2*BYTE_W] : word[2*BYTE_W-1:0];

   always_comb begin
      data = '0;
      case (funct3)
         F3_B:    data = {{(XLEN-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
         F3_H:    data = {{(XLEN-2*BYTE_W){half_sel[2*BYTE_W-1]}}, half_sel};
         F3_W:    data = word;
         F3_BU:   data = {{(XLEN-BYTE_W){1'b0}}, byte_sel};
         F3_HU:   data = {{(XLEN-2*BYTE_W){1'b0}}, half_sel};
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory_param.sv
// Multi-cycle byte-addressed data memory for the MEM stage: RV32 loads/stores,
// configurable latency, BUSYWAIT stall handshake and ERROR for rejected requests.
module data_memory_param
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4
)
(
   input  logic            CLK,
   input  logic            RESET,
   input  logic            READ,
   input  logic            WRITE,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] ADDRESS,
   input  logic [XLEN-1:0] WRITEDATA,
   output logic [XLEN-1:0] READDATA,
   output logic            BUSYWAIT,
   output logic            ERROR
);

   localparam int              DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_t                  state_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [2:0]              f3_reg;
   logic [XLEN-1:0]         wdata_reg;
   logic                    write_reg;
   logic [XLEN-1:0]         rdata_reg;
   logic                    error_reg;

   logic [BYTE_W-1:0]       mem [DEPTH];

   logic                    request;
   logic                    out_of_range;
   logic                    misaligned;
   logic                    bad_f3;
   logic                    illegal;
   logic                    finishing;
   logic                    commit;
   logic [NUM_LANES-1:0]    byte_en;
   logic [BYTE_W-1:0]       lane_data [NUM_LANES];
   logic [XLEN-1:0]         raw_word;
   logic [XLEN-1:0]         load_data;

   // ---------------- request legality ----------------
   assign request      = READ | WRITE;
   assign out_of_range = |ADDRESS[XLEN-1:ADDR_WIDTH];

   always_comb begin
      misaligned = 1'b0;
      case (FUNCT3[1:0])
         2'b01:   misaligned = ADDRESS[0];
         2'b10:   misaligned = |ADDRESS[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign bad_f3  = READ ? !load_f3_ok(FUNCT3) : !store_f3_ok(FUNCT3);
   assign illegal = (READ & WRITE) | out_of_range | misaligned | bad_f3;

   // ---------------- access sequencing ----------------
   assign finishing = (state_reg == BUSY) && (cnt_reg == '0);
   assign commit    = finishing && write_reg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         f3_reg    <= '0;
         wdata_reg <= '0;
         write_reg <= 1'b0;
         rdata_reg <= '0;
         error_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (request) begin
                  addr_reg  <= ADDRESS[ADDR_WIDTH-1:0];
                  f3_reg    <= FUNCT3;
                  wdata_reg <= WRITEDATA;
                  write_reg <= WRITE;
                  if (illegal) begin
                     state_reg <= DONE;
                     error_reg <= 1'b1;
                     rdata_reg <= '0;
                  end else begin
                     state_reg <= BUSY;
                     cnt_reg   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else begin
                  if (!write_reg)
                     rdata_reg <= load_data;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               error_reg <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Reset forces the stall low even if a request is already being presented.
   assign BUSYWAIT = ~RESET & (((state_reg == IDLE) & request) | (state_reg == BUSY));
   assign READDATA = rdata_reg;
   assign ERROR    = error_reg;

   // ---------------- store byte lanes ----------------
   always_comb begin
      byte_en = '0;
      case (f3_reg[1:0])
         2'b00:   byte_en = 4'b0001 << addr_reg[1:0];
         2'b01:   byte_en = 4'b0011 << addr_reg[1:0];
         2'b10:   byte_en = 4'b1111;
         default: byte_en = '0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         // SB/SH replicate the low byte/halfword so every enabled lane sees its data.
         assign lane_data[gi] = (f3_reg[1:0] == 2'b00) ? wdata_reg[BYTE_W-1:0] :
                                (f3_reg[1:0] == 2'b01) ? wdata_reg[BYTE_W*(gi%2) +: BYTE_W] :
                                                         wdata_reg[BYTE_W*gi +: BYTE_W];
         assign raw_word[BYTE_W*gi +: BYTE_W] = mem[{addr_reg[ADDR_WIDTH-1:2], 2'(gi)}];
      end
   endgenerate

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++)
            mem[ADDR_WIDTH'(i)] <= '0;
      end else if (commit) begin
         for (int i = 0; i < NUM_LANES; i++)
            if (byte_en[i])
               mem[{addr_reg[ADDR_WIDTH-1:2], 2'(i)}] <= lane_data[i];
      end
   end

   // ---------------- load extraction ----------------
   mem_load_align u_align (
      .addr_lo (addr_reg[1:0]),
      .funct3  (f3_reg),
      .word    (raw_word),
      .data    (load_data)
   );

endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: LATENCY=4 and LATENCY=1 instances,
// expected results queued at request time and popped when the access completes.
module tb_data_memory_param;
   import mem_pkg::*;

   logic        CLK;
   logic        RESET;

   logic        rd4, wr4, busy4, err4;
   logic [2:0]  f34;
   logic [31:0] ad4, wd4, rdata4;

   logic        rd1, wr1, busy1, err1;
   logic [2:0]  f31;
   logic [31:0] ad1, wd1, rdata1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          busy;
   } exp_t;

   exp_t exp_q[$];

   data_memory_param #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (
      .CLK(CLK), .RESET(RESET), .READ(rd4), .WRITE(wr4), .FUNCT3(f34),
      .ADDRESS(ad4), .WRITEDATA(wd4), .READDATA(rdata4), .BUSYWAIT(busy4), .ERROR(err4)
   );

   data_memory_param #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .READ(rd1), .WRITE(wr1), .FUNCT3(f31),
      .ADDRESS(ad1), .WRITEDATA(wd1), .READDATA(rdata1), .BUSYWAIT(busy1), .ERROR(err1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int dut, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (dut == 1) begin
         rd1 = rd; wr1 = wr; f31 = f3; ad1 = addr; wd1 = wdata;
      end else begin
         rd4 = rd; wr4 = wr; f34 = f3; ad4 = addr; wd4 = wdata;
      end
   endtask

   function automatic logic busy_of(input int dut);
      return (dut == 1) ? busy1 : busy4;
   endfunction

   // One complete access: drive at a falling edge, hold through the sampling
   // edge, count stall cycles, then compare the DONE-cycle outputs.
   task automatic req(input string tag, input int dut, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_busy);
      exp_t e;
      exp_t got;
      int   n;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.busy  = exp_busy;
      exp_q.push_back(e);
      @(negedge CLK);
      drive(dut, rd, wr, f3, addr, wdata);
      #1;
      n = 0;
      while (busy_of(dut) && n < 40) begin
         n++;
         @(negedge CLK);
         if (n == 1) drive(dut, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         #1;
      end
      drive(dut, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      got = exp_q.pop_front();
      chk({tag, " busy_cycles"}, 32'(n), 32'(got.busy));
      chk({tag, " readdata"}, (dut == 1) ? rdata1 : rdata4, got.rdata);
      chk({tag, " error"}, 32'((dut == 1) ? err1 : err4), 32'(got.err));
      $display("txn %s dut_lat=%0d busy=%0d rdata=%h err=%b", tag, (dut == 1) ? 1 : 4, n,
               (dut == 1) ? rdata1 : rdata4, (dut == 1) ? err1 : err4);
   endtask

   initial begin
      logic [5:0] pat;
      RESET = 1'b1;
      drive(4, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
      drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (2) @(negedge CLK);
      #1;
      chk("reset busywait", 32'(busy4), 32'h0);
      chk("reset readdata", rdata4, 32'h0);
      chk("reset error", 32'(err4), 32'h0);
      chk("reset state", 32'(dut4.state_reg), 32'(IDLE));
      $display("txn reset busy=%b rdata=%h err=%b", busy4, rdata4, err4);
      drive(4, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge CLK);
      RESET = 1'b0;

      // Legal accesses, LATENCY=4
      req("SW 10",   4, 0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h00000000, 0, 5);
      req("LW 10",   4, 1, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 5);
      req("LBU 10",  4, 1, 0, F3_BU, 32'h10, 32'h0,        32'h000000EF, 0, 5);
      req("LB 13",   4, 1, 0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 0, 5);
      req("LH 12",   4, 1, 0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 0, 5);
      req("LHU 12",  4, 1, 0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 0, 5);
      req("SB 11",   4, 0, 1, F3_B,  32'h11, 32'hFFFFFF7F, 32'h0000DEAD, 0, 5);
      req("LW 10 b", 4, 1, 0, F3_W,  32'h10, 32'h0,        32'hDEAD7FEF, 0, 5);
      req("SH 12",   4, 0, 1, F3_H,  32'h12, 32'hABCD1234, 32'hDEAD7FEF, 0, 5);
      req("LW 10 h", 4, 1, 0, F3_W,  32'h10, 32'h0,        32'h12347FEF, 0, 5);

      // Rejected requests, each followed by a read-back
      req("LW 11 mis",  4, 1, 0, F3_W,  32'h11,  32'h0,        32'h0,        1, 1);
      req("LW 10 c1",   4, 1, 0, F3_W,  32'h10,  32'h0,        32'h12347FEF, 0, 5);
      req("SH 01 mis",  4, 0, 1, F3_H,  32'h01,  32'h00005555, 32'h0,        1, 1);
      req("LW 00 c2",   4, 1, 0, F3_W,  32'h00,  32'h0,        32'h00000000, 0, 5);
      req("LW 400 oor", 4, 1, 0, F3_W,  32'h400, 32'h0,        32'h0,        1, 1);
      req("LW 10 c3",   4, 1, 0, F3_W,  32'h10,  32'h0,        32'h12347FEF, 0, 5);
      req("RW 10",      4, 1, 1, F3_W,  32'h10,  32'h11111111, 32'h0,        1, 1);
      req("LW 10 c4",   4, 1, 0, F3_W,  32'h10,  32'h0,        32'h12347FEF, 0, 5);
      req("LD f3 011",  4, 1, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 1);
      req("ST f3 011",  4, 0, 1, 3'b011, 32'h14, 32'h99999999, 32'h0,        1, 1);
      req("LW 14 c5",   4, 1, 0, F3_W,  32'h14,  32'h0,        32'h00000000, 0, 5);
      req("LW 10 c6",   4, 1, 0, F3_W,  32'h10,  32'h0,        32'h12347FEF, 0, 5);

      // Reset in the middle of a store
      @(negedge CLK);
      drive(4, 1'b0, 1'b1, F3_W, 32'h20, 32'hAAAAAAAA);
      @(negedge CLK);
      drive(4, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge CLK);
      #1;
      chk("abort in busy", 32'(busy4), 32'h1);
      RESET = 1'b1;
      #1;
      chk("abort busywait", 32'(busy4), 32'h0);
      chk("abort readdata", rdata4, 32'h0);
      chk("abort error", 32'(err4), 32'h0);
      chk("abort state", 32'(dut4.state_reg), 32'(IDLE));
      $display("txn abort SW 20 busy=%b rdata=%h err=%b", busy4, rdata4, err4);
      @(negedge CLK);
      RESET = 1'b0;
      req("LW 20 post", 4, 1, 0, F3_W, 32'h20, 32'h0, 32'h00000000, 0, 5);
      req("LW 10 post", 4, 1, 0, F3_W, 32'h10, 32'h0, 32'h00000000, 0, 5);

      // LATENCY=1: held store runs twice with a one-cycle BUSYWAIT gap
      @(negedge CLK);
      drive(1, 1'b0, 1'b1, F3_W, 32'h08, 32'h01020304);
      #1;
      for (int k = 0; k < 6; k++) begin
         pat[5-k] = busy1;
         if (k == 2 || k == 5) chk($sformatf("held done%0d error", k), 32'(err1), 32'h0);
         if (k == 5) drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         @(negedge CLK);
         #1;
      end
      chk("held busy pattern", 32'(pat), 32'h36);
      chk("held idle after", 32'(busy1), 32'h0);
      $display("txn held SW 08 pattern=%b", pat);
      req("L1 LW 08", 1, 1, 0, F3_W, 32'h08, 32'h0, 32'h01020304, 0, 2);
      req("L1 LB 0B", 1, 1, 0, F3_B, 32'h0B, 32'h0, 32'h00000001, 0, 2);
      req("L1 LH 0A", 1, 1, 0, F3_H, 32'h0A, 32'h0, 32'h00000102, 0, 2);
      req("L1 LH 09", 1, 1, 0, F3_H, 32'h09, 32'h0, 32'h00000000, 1, 1);

      chk("queue drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
